code_lookup_arbiter: RTL



---
 rtl/code_lookup_arbiter_pkg.sv | 39 +++
 rtl/code_lookup_arbiter_rr_picker.sv | 39 +++
 rtl/code_lookup_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/code_lookup_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// code_lookup_pkg
//
// Shared types and constants for the code lookup arbiter:
//   state_t        - arbiter FSM states (IDLE, LOOKUP, HOLD)
//   code_t         - 2-bit code / lookup result
//   TABLE_SIZE     - number of lookup entries (2**2)
//   DEFAULT_TABLE  - table contents after reset
//   lookup()       - translates a code through a table with a full case
// ----------------------------------------------------------------------------
package code_lookup_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        HOLD   = 2'd2
    } state_t;

    typedef logic [1:0] code_t;

    localparam int unsigned TABLE_SIZE = 4;

    // Entry i is the value returned for code i.
    localparam code_t DEFAULT_TABLE [TABLE_SIZE] = '{2'd2, 2'd3, 2'd0, 2'd1};

    // Every code value has exactly one arm; no default can shadow an entry.
    function automatic code_t lookup(input code_t c, input code_t tbl [TABLE_SIZE]);
        code_t val;
        val = tbl[0];
        unique case (c)
            2'd0: val = tbl[0];
            2'd1: val = tbl[1];
            2'd2: val = tbl[2];
            2'd3: val = tbl[3];
        endcase
        return val;
    endfunction

endpackage

// File: rtl/code_lookup_arbiter_rr_picker.sv
// ----------------------------------------------------------------------------
// rr_picker
//
// Combinational round-robin selector. Scans req starting at index ptr and
// wrapping around; the first set bit wins.
//
// Parameters:
//   N_REQ   number of requesters (2..8)
// Ports:
//   req     input  [N_REQ-1:0]  request vector
//   ptr     input  [PTR_W-1:0]  highest-priority index for this scan
//   winner  output [PTR_W-1:0]  index of the selected requester
//   any     output              at least one request is set (winner valid)
// ----------------------------------------------------------------------------
module rr_picker #(
    parameter int unsigned N_REQ = 4,
    localparam int unsigned PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] winner,
    output logic             any
);

    always_comb begin
        int unsigned idx;
        winner = '0;
        any    = 1'b0;
        idx    = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = (32'(ptr) + i) % N_REQ;
            if (!any && req[PTR_W'(idx)]) begin
                any    = 1'b1;
                winner = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/code_lookup_arbiter.sv
// ----------------------------------------------------------------------------
// code_lookup_arbiter
//
// Shares a single 2-bit code-to-value lookup stage between N_REQ requesters.
// A round-robin pick grants one requester, its code is latched on the grant
// edge, translated through a 4-entry table and returned with valid/ready.
// One transaction takes at least three cycles: IDLE -> LOOKUP -> HOLD.
//
// Parameters:
//   N_REQ      number of requesters (2..8)
//   DATA_W     code / result width (fixed at 2)
// Ports:
//   clk        input               system clock, posedge
//   rst_n      input               asynchronous active-low reset
//   req        input  [N_REQ-1:0]  level requests, held until served
//   code       input  [N_REQ*DATA_W-1:0] packed codes, requester i at
//                                  [i*DATA_W +: DATA_W]
//   rsp_ready  input               granted requester accepts the result
//   gnt        output [N_REQ-1:0]  one-hot grant, held for the transaction
//   rsp_valid  output              result valid
//   rsp_data   output [DATA_W-1:0] looked-up value
//
// Optional feature, macro LUT_WRITE_EN:
//   cfg_we     input               table write enable (accepted in any state)
//   cfg_addr   input  [DATA_W-1:0] table entry to write
//   cfg_data   input  [DATA_W-1:0] new entry value
// Without the macro the table is the constant default and these ports do not
// exist.
// ----------------------------------------------------------------------------
module code_lookup_arbiter
    import code_lookup_pkg::*;
#(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] code,
    input  logic                    rsp_ready,
`ifdef LUT_WRITE_EN
    input  logic                    cfg_we,
    input  logic [DATA_W-1:0]       cfg_addr,
    input  logic [DATA_W-1:0]       cfg_data,
`endif
    output logic [N_REQ-1:0]        gnt,
    output logic                    rsp_valid,
    output logic [DATA_W-1:0]       rsp_data
);

    localparam int unsigned PTR_W = $clog2(N_REQ);

    state_t           state_q, state_d;
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] win_q;
    code_t            code_q;
    code_t            rsp_data_q;

    logic [PTR_W-1:0] pick_idx;
    logic             pick_any;
    code_t            pick_code;
    code_t            lut_val;
    code_t            tbl [TABLE_SIZE];

    // ------------------------------------------------------------------
    // Round-robin selection
    // ------------------------------------------------------------------
    rr_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .req    (req),
        .ptr    (ptr_q),
        .winner (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        pick_code = code[pick_idx*DATA_W +: DATA_W];
    end

    // ------------------------------------------------------------------
    // Lookup table
    // ------------------------------------------------------------------
`ifdef LUT_WRITE_EN
    // A write lands at the edge, so a LOOKUP of the same entry in the same
    // cycle still reads the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl <= DEFAULT_TABLE;
        end else if (cfg_we) begin
            tbl[cfg_addr] <= cfg_data;
        end
    end
`else
    always_comb begin
        tbl = DEFAULT_TABLE;
    end
`endif

    always_comb begin
        lut_val = lookup(code_q, tbl);
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pick_any) state_d = LOOKUP;
            LOOKUP:  state_d = HOLD;
            HOLD:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // Grant and valid are decoded from the state so an asynchronous reset
    // clears them immediately along with the state.
    // ------------------------------------------------------------------
    always_comb begin
        gnt       = '0;
        rsp_valid = 1'b0;
        rsp_data  = rsp_data_q;
        if (state_q != IDLE) begin
            gnt = N_REQ'(1) << win_q;
        end
        if (state_q == HOLD) begin
            rsp_valid = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            win_q      <= '0;
            code_q     <= '0;
            rsp_data_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // The code is sampled only here; later changes are ignored.
                    if (pick_any) begin
                        win_q  <= pick_idx;
                        code_q <= pick_code;
                    end
                end
                LOOKUP: begin
                    rsp_data_q <= lut_val;
                end
                HOLD: begin
                    // Served requester drops to lowest priority.
                    if (rsp_ready) begin
                        ptr_q <= (win_q == PTR_W'(N_REQ - 1)) ? '0 : win_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
